// File: rtl/ctrl_pipe_hazard_if.sv
// ctrl_pipe_hazard_if: decoded ID-stage bundle handed from the decoder to the hazard/control pipe.
//   master : decoder side, drives the bundle
//   slave  : ctrl_pipe_hazard side, consumes the bundle
// Signals:
//   id_valid                                  ID holds a real instruction
//   id_rs1, id_rs2, id_rd                     register specifiers
//   id_rsuse                                  bit1 = rs1 read, bit0 = rs2 read
//   id_regwrite, id_memread, id_memwrite,
//   id_branch, id_memtoreg, id_jump, id_aluop decoded controls
interface ctrl_pipe_hazard_if;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic [4:0] id_rd;
   logic [1:0] id_rsuse;
   logic       id_regwrite;
   logic       id_memread;
   logic       id_memwrite;
   logic       id_branch;
   logic [1:0] id_memtoreg;
   logic [1:0] id_jump;
   logic [1:0] id_aluop;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_rsuse, id_regwrite, id_memread,
             id_memwrite, id_branch, id_memtoreg, id_jump, id_aluop
   );

   modport slave (
      input id_valid, id_rs1, id_rs2, id_rd, id_rsuse, id_regwrite, id_memread,
            id_memwrite, id_branch, id_memtoreg, id_jump, id_aluop
   );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard: carries the decoded control bundle through the EX/MEM/WB pipeline registers
// of the 5-stage RV32I core, detects load-use hazards (stall IF/ID one cycle), squashes the
// wrong path on an EX redirect, generates EX operand forwarding selects and keeps saturating
// stall/flush performance counters.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id                  decoded ID bundle (slave modport)
//   ex_redirect         EX resolved a taken branch/jal/jalr
//   freeze              data memory busy, whole pipeline holds
//   stall, flush_id     hold PC + IF/ID, squash IF/ID
//   ex_*, mem_*, wb_*   stage controls, gated by the stage valid
//   fwd_a, fwd_b        EX operand source: 00 regfile, 10 MEM result, 01 WB result
//   stall_cnt, flush_cnt saturating performance counters
module ctrl_pipe_hazard #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   ctrl_pipe_hazard_if.slave id,
   input  logic             ex_redirect,
   input  logic             freeze,
   output logic             stall,
   output logic             flush_id,
   output logic             ex_valid,
   output logic             ex_regwrite,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_branch,
   output logic [1:0]       ex_memtoreg,
   output logic [1:0]       ex_jump,
   output logic [1:0]       ex_aluop,
   output logic [4:0]       ex_rd,
   output logic             mem_valid,
   output logic             mem_regwrite,
   output logic             mem_memread,
   output logic             mem_memwrite,
   output logic [1:0]       mem_memtoreg,
   output logic [4:0]       mem_rd,
   output logic             wb_valid,
   output logic             wb_regwrite,
   output logic [1:0]       wb_memtoreg,
   output logic [4:0]       wb_rd,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [1:0] rsuse;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic [1:0] memtoreg;
      logic [1:0] jump;
      logic [1:0] aluop;
   } ex_stage_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic [1:0] memtoreg;
   } mem_stage_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic [1:0] memtoreg;
   } wb_stage_t;

   ex_stage_t  ex_q, ex_d, id_bundle;
   mem_stage_t mem_q, mem_d;
   wb_stage_t  wb_q, wb_d;
   logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;
   logic lu, rd_ok;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A MEM-stage load has no result yet, so it never forwards from MEM.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic used,
                                          input mem_stage_t m, input wb_stage_t w);
      logic [1:0] sel;
      sel = 2'b00;
      if (used && rs != 5'd0) begin
         if (m.valid && m.regwrite && !m.memread && m.rd == rs) begin
            sel = 2'b10;
         end else if (w.valid && w.regwrite && w.rd == rs) begin
            sel = 2'b01;
         end
      end
      return sel;
   endfunction

   // Invalid ID slots enter EX as a clean bubble.
   always_comb begin
      id_bundle = '0;
      if (id.id_valid) begin
         id_bundle.valid    = 1'b1;
         id_bundle.rs1      = id.id_rs1;
         id_bundle.rs2      = id.id_rs2;
         id_bundle.rsuse    = id.id_rsuse;
         id_bundle.rd       = id.id_rd;
         id_bundle.regwrite = id.id_regwrite;
         id_bundle.memread  = id.id_memread;
         id_bundle.memwrite = id.id_memwrite;
         id_bundle.branch   = id.id_branch;
         id_bundle.memtoreg = id.id_memtoreg;
         id_bundle.jump     = id.id_jump;
         id_bundle.aluop    = id.id_aluop;
      end
   end

   assign lu = id.id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) &
               ((id.id_rsuse[1] & (id.id_rs1 == ex_q.rd)) |
                (id.id_rsuse[0] & (id.id_rs2 == ex_q.rd)));

   // rd_ok stays asserted across a freeze because EX holds the redirecting instruction.
   assign rd_ok = ex_redirect & ex_q.valid;

   assign stall    = freeze | (~rd_ok & lu);
   assign flush_id = ~freeze & rd_ok;

   always_comb begin
      ex_d   = ex_q;
      mem_d  = mem_q;
      wb_d   = wb_q;
      scnt_d = scnt_q;
      fcnt_d = fcnt_q;
      if (!freeze) begin
         mem_d.valid    = ex_q.valid;
         mem_d.rd       = ex_q.rd;
         mem_d.regwrite = ex_q.regwrite;
         mem_d.memread  = ex_q.memread;
         mem_d.memwrite = ex_q.memwrite;
         mem_d.memtoreg = ex_q.memtoreg;
         wb_d.valid     = mem_q.valid;
         wb_d.rd        = mem_q.rd;
         wb_d.regwrite  = mem_q.regwrite;
         wb_d.memtoreg  = mem_q.memtoreg;
         if (rd_ok) begin
            ex_d   = '0;
            fcnt_d = sat_inc(fcnt_q);
         end else if (lu) begin
            ex_d   = '0;
            scnt_d = sat_inc(scnt_q);
         end else begin
            ex_d = id_bundle;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q   <= '0;
         mem_q  <= '0;
         wb_q   <= '0;
         scnt_q <= '0;
         fcnt_q <= '0;
      end else begin
         ex_q   <= ex_d;
         mem_q  <= mem_d;
         wb_q   <= wb_d;
         scnt_q <= scnt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign ex_valid    = ex_q.valid;
   assign ex_regwrite = ex_q.valid & ex_q.regwrite;
   assign ex_memread  = ex_q.valid & ex_q.memread;
   assign ex_memwrite = ex_q.valid & ex_q.memwrite;
   assign ex_branch   = ex_q.valid & ex_q.branch;
   assign ex_memtoreg = {2{ex_q.valid}} & ex_q.memtoreg;
   assign ex_jump     = {2{ex_q.valid}} & ex_q.jump;
   assign ex_aluop    = {2{ex_q.valid}} & ex_q.aluop;
   assign ex_rd       = {5{ex_q.valid}} & ex_q.rd;

   assign mem_valid    = mem_q.valid;
   assign mem_regwrite = mem_q.valid & mem_q.regwrite;
   assign mem_memread  = mem_q.valid & mem_q.memread;
   assign mem_memwrite = mem_q.valid & mem_q.memwrite;
   assign mem_memtoreg = {2{mem_q.valid}} & mem_q.memtoreg;
   assign mem_rd       = {5{mem_q.valid}} & mem_q.rd;

   assign wb_valid    = wb_q.valid;
   assign wb_regwrite = wb_q.valid & wb_q.regwrite;
   assign wb_memtoreg = {2{wb_q.valid}} & wb_q.memtoreg;
   assign wb_rd       = {5{wb_q.valid}} & wb_q.rd;

   assign fwd_a = fwd_sel(ex_q.rs1, ex_q.rsuse[1], mem_q, wb_q);
   assign fwd_b = fwd_sel(ex_q.rs2, ex_q.rsuse[0], mem_q, wb_q);

   assign stall_cnt = scnt_q;
   assign flush_cnt = fcnt_q;

endmodule
